psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 102 ++++++++++
 tb/tb_psum_drain.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: snapshots an N x N array of partial sums and streams them out
// in row-major order over a valid/ready handshake.
module psum_drain #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                     clk,
    input  logic                     rstSys,
    input  logic                     start_check,
    input  logic [N*N*W-1:0]         psum_flat,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N*N)-1:0]   out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     missed
);

    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam logic [IW-1:0] LAST = IW'(NE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [W-1:0]  snap [NE];

    assign nidx    = idx + 1'b1;
    assign out_idx = idx;

    always_ff @(posedge clk) begin
        if (rstSys) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            missed    <= 1'b0;
            for (int i = 0; i < NE; i++) begin
                snap[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            // A start request is only honoured from IDLE; anything else is lost
            if (start_check && state != IDLE) begin
                missed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start_check) begin
                        for (int i = 0; i < NE; i++) begin
                            snap[i] <= psum_flat[i*W +: W];
                        end
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_data  <= snap[0];
                    out_last  <= (LAST == '0);
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx      <= nidx;
                            out_data <= snap[nidx];
                            out_last <= (nidx == LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: a queue of expected entries is taken
// from psum_flat at each capture and compared beat by beat.
module tb_psum_drain;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int NE = N * N;
    localparam int IW = $clog2(NE);

    logic              clk = 1'b0;
    logic              rstSys;
    logic              start_check;
    logic [NE*W-1:0]   psum_flat;
    logic              out_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              missed;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    psum_drain #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rstSys      (rstSys),
        .start_check (start_check),
        .psum_flat   (psum_flat),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstSys      = 1'b1;
        start_check = 1'b0;
        out_ready   = 1'b0;
        tick();
        rstSys = 1'b0;
    endtask

    task automatic load_rand();
        for (int k = 0; k < NE; k++) begin
            psum_flat[k*W +: W] = W'($urandom);
        end
    endtask

    // Pulses start_check for one edge and records what the snapshot must hold
    task automatic capture();
        exp_q.delete();
        for (int k = 0; k < NE; k++) begin
            exp_q.push_back(psum_flat[k*W +: W]);
        end
        start_check = 1'b1;
        tick();
        start_check = 1'b0;
    endtask

    task automatic test_reset();
        psum_flat = '0;
        do_reset();
        checks++;
        if ({out_valid, out_last, busy, done, missed} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags act v=%b l=%b b=%b d=%b m=%b req all 0",
                     out_valid, out_last, busy, done, missed);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data act %h req 0000", out_data);
        end
        checks++;
        if (out_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx act %0d req 0", out_idx);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                psum_flat[(r*N+c)*W +: W] = W'(256 * r + c);
            end
        end
        out_ready = 1'b1;
        capture();
        checks++;
        if ({busy, out_valid, out_data} !== {2'b10, 16'h0000}) begin
            errors++;
            $display("FAIL capture_state act b=%b v=%b d=%h req b=1 v=0 d=0000",
                     busy, out_valid, out_data);
        end
        tick();
        for (int k = 0; k < NE; k++) begin
            e = W'(256 * (k / N) + (k % N));
            checks++;
            if ({out_valid, out_idx, out_data, out_last} !==
                {1'b1, IW'(k), e, (k == NE - 1)}) begin
                errors++;
                $display("FAIL basic_beat%0d act v=%b i=%0d d=%h l=%b req d=%h",
                         k, out_valid, out_idx, out_data, out_last, e);
            end
            tick();
        end
        checks++;
        if ({done, out_valid, busy, out_data} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL basic_done act d=%b v=%b b=%b data=%h req 1 0 0 0000",
                     done, out_valid, busy, out_data);
        end
        tick();
        checks++;
        if ({done, busy, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle act d=%b b=%b v=%b req 000", done, busy, out_valid);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        int stalls = 0;
        int cyc = 0;
        load_rand();
        out_ready = 1'b1;
        capture();
        tick();
        while (k < NE && cyc < 200) begin
            cyc++;
            checks++;
            if ({out_valid, out_idx, out_data, out_last} !==
                {1'b1, IW'(k), exp_q[k], (k == NE - 1)}) begin
                errors++;
                $display("FAIL stall_beat%0d act v=%b i=%0d d=%h req d=%h",
                         k, out_valid, out_idx, out_data, exp_q[k]);
            end
            if (k == 5 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (out_ready) k++;
        end
        checks++;
        if (k != NE || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_end act k=%0d done=%b req k=%0d done=1", k, done, NE);
        end
        tick();
    endtask

    task automatic test_immunity();
        load_rand();
        out_ready = 1'b1;
        capture();
        psum_flat = '1;
        tick();
        for (int k = 0; k < NE; k++) begin
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, IW'(k), exp_q[k]}) begin
                errors++;
                $display("FAIL immune_beat%0d act v=%b i=%0d d=%h req d=%h",
                         k, out_valid, out_idx, out_data, exp_q[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL immune_done act %b req 1", done);
        end
        tick();
    endtask

    task automatic test_missed();
        checks++;
        if (missed !== 1'b0) begin
            errors++;
            $display("FAIL missed_pre act %b req 0", missed);
        end
        load_rand();
        out_ready = 1'b1;
        capture();
        tick();
        for (int k = 0; k < NE; k++) begin
            checks++;
            if ({out_valid, out_idx, out_data, out_last} !==
                {1'b1, IW'(k), exp_q[k], (k == NE - 1)}) begin
                errors++;
                $display("FAIL missed_beat%0d act v=%b i=%0d d=%h req d=%h",
                         k, out_valid, out_idx, out_data, exp_q[k]);
            end
            start_check = (k == 7);
            if (k == 7) psum_flat = ~psum_flat;
            tick();
        end
        start_check = 1'b0;
        checks++;
        if ({done, missed} !== 2'b11) begin
            errors++;
            $display("FAIL missed_done act done=%b missed=%b req 11", done, missed);
        end
        tick();
        tick();
        checks++;
        if ({missed, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL missed_sticky act m=%b b=%b v=%b req 100", missed, busy, out_valid);
        end
        do_reset();
        checks++;
        if (missed !== 1'b0) begin
            errors++;
            $display("FAIL missed_clear act %b req 0", missed);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        load_rand();
        out_ready = 1'b1;
        capture();
        tick();
        for (int k = 0; k < 9; k++) tick();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b1, IW'(9), exp_q[9]}) begin
            errors++;
            $display("FAIL abort_at9 act v=%b i=%0d d=%h req i=9 d=%h",
                     out_valid, out_idx, out_data, exp_q[9]);
        end
        rstSys = 1'b1;
        #3;
        checks++;
        if ({out_valid, busy} !== 2'b11) begin
            errors++;
            $display("FAIL abort_async act v=%b b=%b req 11", out_valid, busy);
        end
        tick();
        rstSys = 1'b0;
        checks++;
        if ({out_valid, busy, done, out_data} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL abort_state act v=%b b=%b d=%b data=%h req 0",
                     out_valid, busy, done, out_data);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_nodone act %0d active cycles req 0", seen);
        end
        load_rand();
        capture();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, IW'(k), exp_q[k]}) begin
                errors++;
                $display("FAIL restart_beat%0d act v=%b i=%0d d=%h req d=%h",
                         k, out_valid, out_idx, out_data, exp_q[k]);
            end
            tick();
        end
    endtask

    task automatic test_reset_start_same();
        rstSys      = 1'b1;
        start_check = 1'b1;
        out_ready   = 1'b1;
        tick();
        rstSys      = 1'b0;
        start_check = 1'b0;
        checks++;
        if ({busy, missed, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_start act b=%b m=%b v=%b req 000", busy, missed, out_valid);
        end
        tick();
        checks++;
        if ({busy, missed, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_start_after act b=%b m=%b v=%b req 000", busy, missed, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int run = 0; run < 3; run++) begin
            int k = 0;
            int cyc = 0;
            load_rand();
            out_ready = 1'b1;
            capture();
            tick();
            while (k < NE && cyc < 300) begin
                cyc++;
                checks++;
                if ({out_valid, out_idx, out_data, out_last} !==
                    {1'b1, IW'(k), exp_q[k], (k == NE - 1)}) begin
                    errors++;
                    $display("FAIL b2b%0d_beat%0d act v=%b i=%0d d=%h req d=%h",
                             run, k, out_valid, out_idx, out_data, exp_q[k]);
                end
                out_ready = 1'($urandom_range(0, 1));
                tick();
                if (out_ready) k++;
            end
            checks++;
            if (k != NE || done !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_end act k=%0d done=%b req k=%0d done=1",
                         run, k, done, NE);
            end
            tick();
        end
        checks++;
        if (missed !== 1'b0) begin
            errors++;
            $display("FAIL b2b_missed act %b req 0", missed);
        end
    endtask

    initial begin
        rstSys      = 1'b1;
        start_check = 1'b0;
        out_ready   = 1'b0;
        psum_flat   = '0;
        test_reset();
        test_basic();
        test_stall();
        test_immunity();
        test_missed();
        test_reset_mid();
        test_reset_start_same();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
